// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Control unit for a 5-stage RV32I pipeline. It owns the DX/XM/MW control
// pipeline registers. From them, plus the decode-stage fields, it derives the
// execute/memory/writeback selects, operand bypass selects, interlocks and
// the branch/jump redirect. All outputs are combinational from the stage
// registers and the decode inputs, so the DX controls appear one cycle after
// an instruction is presented at decode.
module pipeline_hazard_ctrl #(
  parameter int NREGS     = 32,
  parameter int ADDRW     = $clog2(NREGS),
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             valid_d,
  input  logic [6:0]       opcode_d,
  input  logic [2:0]       funct3_d,
  input  logic [6:0]       funct7_d,
  input  logic [ADDRW-1:0] addr_rs1_d,
  input  logic [ADDRW-1:0] addr_rs2_d,
  input  logic [ADDRW-1:0] addr_rd_d,
  input  logic             br_eq,
  input  logic             br_lt,
  output logic             stall_f,
  output logic             flush_fd,
  output logic             pc_sel,
  output logic             br_un,
  output logic [1:0]       a_sel,
  output logic [1:0]       b_sel,
  output logic [1:0]       rs1_fwd_sel,
  output logic [1:0]       rs2_fwd_sel,
  output logic [3:0]       alu_sel,
  output logic             mem_rw,
  output logic [1:0]       wb_sel,
  output logic             reg_wen,
  output logic [ADDRW-1:0] reg_waddr
);

  // RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  // Opcode classes carried down the pipe instead of the raw opcode
  localparam logic [3:0] CL_NONE   = 4'd0;
  localparam logic [3:0] CL_R      = 4'd1;
  localparam logic [3:0] CL_I      = 4'd2;
  localparam logic [3:0] CL_LOAD   = 4'd3;
  localparam logic [3:0] CL_STORE  = 4'd4;
  localparam logic [3:0] CL_BRANCH = 4'd5;
  localparam logic [3:0] CL_JAL    = 4'd6;
  localparam logic [3:0] CL_JALR   = 4'd7;
  localparam logic [3:0] CL_LUI    = 4'd8;
  localparam logic [3:0] CL_AUIPC  = 4'd9;
  localparam logic [3:0] CL_SYS    = 4'd10;
  localparam logic [3:0] CL_ILL    = 4'd11;

  // ALU operations
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SRL  = 4'd3;
  localparam logic [3:0] ALU_SRA  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_NOP  = 4'd10;

  // Operand mux and writeback encodings
  localparam logic [1:0] SEL_REG   = 2'b00;
  localparam logic [1:0] SEL_PCIMM = 2'b01;
  localparam logic [1:0] SEL_WX    = 2'b10;
  localparam logic [1:0] SEL_MX    = 2'b11;
  localparam logic [1:0] WB_MEM    = 2'd0;
  localparam logic [1:0] WB_ALU    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  typedef struct packed {
    logic             valid;
    logic [3:0]       cls;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [ADDRW-1:0] rs1;
    logic [ADDRW-1:0] rs2;
    logic [ADDRW-1:0] rd;
  } stage_t;

  // Map opcode/funct fields to a class; unsupported encodings become CL_ILL
  function automatic logic [3:0] classify(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7);
    logic [3:0] cls;
    cls = CL_ILL;
    case (op)
      OP_R: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) cls = CL_R;
        else cls = CL_ILL;
      end
      OP_I: begin
        if (f3 == 3'd1) cls = (f7 == 7'h00) ? CL_I : CL_ILL;
        else if (f3 == 3'd5) cls = (f7 == 7'h00 || f7 == 7'h20) ? CL_I : CL_ILL;
        else cls = CL_I;
      end
      OP_LOAD:   cls = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? CL_ILL : CL_LOAD;
      OP_STORE:  cls = (f3 <= 3'd2) ? CL_STORE : CL_ILL;
      OP_BRANCH: cls = (f3 == 3'd2 || f3 == 3'd3) ? CL_ILL : CL_BRANCH;
      OP_JAL:    cls = CL_JAL;
      OP_JALR:   cls = (f3 == 3'd0) ? CL_JALR : CL_ILL;
      OP_LUI:    cls = CL_LUI;
      OP_AUIPC:  cls = CL_AUIPC;
      OP_SYS:    cls = CL_SYS;
      default:   cls = CL_ILL;
    endcase
    return cls;
  endfunction

  // A stage produces a register result only for real, writing, non-x0 instructions
  function automatic logic st_writes(input stage_t s);
    logic no_rd;
    no_rd = (s.cls == CL_STORE) || (s.cls == CL_BRANCH) || (s.cls == CL_SYS) ||
            (s.cls == CL_ILL) || (s.cls == CL_NONE);
    return s.valid && !no_rd && (s.rd != {ADDRW{1'b0}});
  endfunction

  function automatic logic uses_rs1(input logic [3:0] cls);
    return !((cls == CL_LUI) || (cls == CL_AUIPC) || (cls == CL_JAL) ||
             (cls == CL_ILL) || (cls == CL_NONE));
  endfunction

  function automatic logic uses_rs2(input logic [3:0] cls);
    return (cls == CL_R) || (cls == CL_STORE) || (cls == CL_BRANCH);
  endfunction

  // True when stage s writes a register that a used decode source reads
  function automatic logic src_hit(input stage_t s, input logic u1, input logic u2,
                                   input logic [ADDRW-1:0] a1, input logic [ADDRW-1:0] a2);
    return st_writes(s) && ((u1 && (s.rd == a1)) || (u2 && (s.rd == a2)));
  endfunction

  // MX beats WX; a load in XM has no data yet so it never feeds MX
  function automatic logic [1:0] fwd_sel(input logic [ADDRW-1:0] src, input stage_t xm,
                                         input stage_t mw);
    logic [1:0] sel;
    if (st_writes(xm) && (xm.cls != CL_LOAD) && (xm.rd == src)) sel = SEL_MX;
    else if (st_writes(mw) && (mw.rd == src)) sel = SEL_WX;
    else sel = SEL_REG;
    return sel;
  endfunction

  function automatic logic branch_cond(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    case (f3)
      3'd0:    t = eq;
      3'd1:    t = !eq;
      3'd4:    t = lt;
      3'd5:    t = !lt;
      3'd6:    t = lt;
      3'd7:    t = !lt;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [3:0] alu_of(input stage_t s);
    logic [3:0] op;
    op = ALU_NOP;
    if (!s.valid) begin
      op = ALU_NOP;
    end else begin
      case (s.cls)
        CL_LUI: op = ALU_NOP;
        CL_AUIPC, CL_JAL, CL_JALR, CL_LOAD, CL_STORE, CL_BRANCH: op = ALU_ADD;
        CL_R, CL_I: begin
          case (s.f3)
            3'd0:    op = (s.cls == CL_R && s.f7 == 7'h20) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = (s.f7 == 7'h20) ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            3'd7:    op = ALU_AND;
            default: op = ALU_NOP;
          endcase
        end
        default: op = ALU_NOP;
      endcase
    end
    return op;
  endfunction

  stage_t r_dx;
  stage_t r_xm;
  stage_t r_mw;
  stage_t w_dec;
  logic   w_use1;
  logic   w_use2;
  logic   w_hazard;
  logic   w_take;
  logic [1:0] w_fwd1;
  logic [1:0] w_fwd2;
  logic   w_unused_fields;

  // Package the decode inputs into stage form and note which sources it reads
  always_comb begin
    w_dec       = '0;
    w_dec.valid = valid_d;
    w_dec.cls   = classify(opcode_d, funct3_d, funct7_d);
    w_dec.f3    = funct3_d;
    w_dec.f7    = funct7_d;
    w_dec.rs1   = addr_rs1_d;
    w_dec.rs2   = addr_rs2_d;
    w_dec.rd    = addr_rd_d;
    w_use1      = valid_d && uses_rs1(w_dec.cls);
    w_use2      = valid_d && uses_rs2(w_dec.cls);
  end

  // Interlock and control-transfer decisions; a redirect always overrides a stall
  always_comb begin
    w_hazard = 1'b0;
    if (BYPASS_EN) begin
      w_hazard = src_hit(r_dx, w_use1, w_use2, addr_rs1_d, addr_rs2_d) &&
                 (r_dx.cls == CL_LOAD);
    end else begin
      w_hazard = src_hit(r_dx, w_use1, w_use2, addr_rs1_d, addr_rs2_d) ||
                 src_hit(r_xm, w_use1, w_use2, addr_rs1_d, addr_rs2_d) ||
                 src_hit(r_mw, w_use1, w_use2, addr_rs1_d, addr_rs2_d);
    end
    w_take = r_dx.valid &&
             ((r_dx.cls == CL_JAL) || (r_dx.cls == CL_JALR) ||
              ((r_dx.cls == CL_BRANCH) && branch_cond(r_dx.f3, br_eq, br_lt)));
    stall_f  = w_hazard && !w_take;
    flush_fd = w_take;
    pc_sel   = w_take;
    br_un    = r_dx.valid && (r_dx.cls == CL_BRANCH) &&
               ((r_dx.f3 == 3'd6) || (r_dx.f3 == 3'd7));
  end

  // Execute-stage operand selects and ALU operation for the DX instruction
  always_comb begin
    w_fwd1 = SEL_REG;
    w_fwd2 = SEL_REG;
    if (BYPASS_EN && r_dx.valid) begin
      if (uses_rs1(r_dx.cls)) w_fwd1 = fwd_sel(r_dx.rs1, r_xm, r_mw);
      else w_fwd1 = SEL_REG;
      if (uses_rs2(r_dx.cls)) w_fwd2 = fwd_sel(r_dx.rs2, r_xm, r_mw);
      else w_fwd2 = SEL_REG;
    end else begin
      w_fwd1 = SEL_REG;
      w_fwd2 = SEL_REG;
    end
    rs1_fwd_sel = w_fwd1;
    rs2_fwd_sel = w_fwd2;
    if (!r_dx.valid) a_sel = SEL_REG;
    else if ((r_dx.cls == CL_BRANCH) || (r_dx.cls == CL_AUIPC) || (r_dx.cls == CL_JAL))
      a_sel = SEL_PCIMM;
    else a_sel = w_fwd1;
    if (!r_dx.valid) b_sel = SEL_REG;
    else if (r_dx.cls == CL_R) b_sel = w_fwd2;
    else b_sel = SEL_PCIMM;
    alu_sel = alu_of(r_dx);
  end

  // Memory and writeback controls from the XM and MW stages
  always_comb begin
    mem_rw = r_xm.valid && (r_xm.cls == CL_STORE);
    if (!r_xm.valid) wb_sel = WB_MEM;
    else if (r_xm.cls == CL_LOAD) wb_sel = WB_MEM;
    else if ((r_xm.cls == CL_JAL) || (r_xm.cls == CL_JALR)) wb_sel = WB_PC4;
    else wb_sel = WB_ALU;
    reg_wen   = st_writes(r_mw);
    reg_waddr = r_mw.valid ? r_mw.rd : {ADDRW{1'b0}};
  end

  // Source/funct fields past DX carry no control meaning downstream
  assign w_unused_fields = ^{r_xm.f3, r_xm.f7, r_xm.rs1, r_xm.rs2,
                             r_mw.f3, r_mw.f7, r_mw.rs1, r_mw.rs2};

  // Advance the control pipe; stall or redirect inserts a bubble into DX
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dx <= '0;
      r_xm <= '0;
      r_mw <= '0;
    end else begin
      r_xm <= r_dx;
      r_mw <= r_xm;
      if (!stall_f && !flush_fd) r_dx <= w_dec;
      else r_dx <= '0;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Drives instruction streams into two instances (forwarding and no-forwarding)
// and checks the interlock/select outputs inline; register writebacks of the
// forwarding instance are predicted into a queue and compared at MW.
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic       clock;
  logic       reset_n;
  logic       valid_m;
  logic       valid_n;
  logic [6:0] opcode_d;
  logic [2:0] funct3_d;
  logic [6:0] funct7_d;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       br_eq, br_lt;

  logic       stall_f, flush_fd, pc_sel, br_un, mem_rw, reg_wen;
  logic [1:0] a_sel, b_sel, rs1_fwd_sel, rs2_fwd_sel, wb_sel;
  logic [3:0] alu_sel;
  logic [4:0] reg_waddr;

  logic       stall_f_n, flush_fd_n, pc_sel_n, br_un_n, mem_rw_n, reg_wen_n;
  logic [1:0] a_sel_n, b_sel_n, rs1_fwd_sel_n, rs2_fwd_sel_n, wb_sel_n;
  logic [3:0] alu_sel_n;
  logic [4:0] reg_waddr_n;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         due;
    logic       wen;
    logic [4:0] waddr;
  } sb_t;
  sb_t sb[$];

  pipeline_hazard_ctrl dut (
    .clock(clock), .reset_n(reset_n), .valid_d(valid_m), .opcode_d(opcode_d),
    .funct3_d(funct3_d), .funct7_d(funct7_d), .addr_rs1_d(rs1_d), .addr_rs2_d(rs2_d),
    .addr_rd_d(rd_d), .br_eq(br_eq), .br_lt(br_lt), .stall_f(stall_f), .flush_fd(flush_fd),
    .pc_sel(pc_sel), .br_un(br_un), .a_sel(a_sel), .b_sel(b_sel), .rs1_fwd_sel(rs1_fwd_sel),
    .rs2_fwd_sel(rs2_fwd_sel), .alu_sel(alu_sel), .mem_rw(mem_rw), .wb_sel(wb_sel),
    .reg_wen(reg_wen), .reg_waddr(reg_waddr)
  );

  pipeline_hazard_ctrl #(.BYPASS_EN(1'b0)) dut_nb (
    .clock(clock), .reset_n(reset_n), .valid_d(valid_n), .opcode_d(opcode_d),
    .funct3_d(funct3_d), .funct7_d(funct7_d), .addr_rs1_d(rs1_d), .addr_rs2_d(rs2_d),
    .addr_rd_d(rd_d), .br_eq(br_eq), .br_lt(br_lt), .stall_f(stall_f_n), .flush_fd(flush_fd_n),
    .pc_sel(pc_sel_n), .br_un(br_un_n), .a_sel(a_sel_n), .b_sel(b_sel_n),
    .rs1_fwd_sel(rs1_fwd_sel_n), .rs2_fwd_sel(rs2_fwd_sel_n), .alu_sel(alu_sel_n),
    .mem_rw(mem_rw_n), .wb_sel(wb_sel_n), .reg_wen(reg_wen_n), .reg_waddr(reg_waddr_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle index used to time-stamp predicted writebacks
  always @(posedge clock) cyc <= cyc + 1;

  task automatic drv(input logic vm, input logic vn, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [4:0] d);
    valid_m = vm; valid_n = vn; opcode_d = op; funct3_d = f3; funct7_d = f7;
    rs1_d = a1; rs2_d = a2; rd_d = d;
  endtask

  // Record the writeback the forwarding instance must show 3 cycles after acceptance
  task automatic push(input logic w, input logic [4:0] a);
    sb_t e;
    e.due = cyc + 3; e.wen = w; e.waddr = a;
    sb.push_back(e);
  endtask

  // Pop any writeback due this cycle; with none due, MW must be idle
  task automatic sb_check();
    sb_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      total++; bad++;
      $display("FAIL wb_missed due=%0d now=%0d rd=%0d", e.due, cyc, e.waddr);
    end
    total++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      if (reg_wen !== e.wen || reg_waddr !== e.waddr) begin
        bad++;
        $display("FAIL wb_cyc%0d got wen=%0b addr=%0d want wen=%0b addr=%0d",
                 cyc, reg_wen, reg_waddr, e.wen, e.waddr);
      end
    end else if (reg_wen !== 1'b0 || reg_waddr !== 5'd0) begin
      bad++;
      $display("FAIL wb_idle_cyc%0d got wen=%0b addr=%0d want wen=0 addr=0",
               cyc, reg_wen, reg_waddr);
    end
  endtask

  task automatic end_cycle();
    sb_check();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drv(1'b0, 1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
      @(negedge clock);
      end_cycle();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    br_eq = 1'b0; br_lt = 1'b0;
    drv(1'b0, 1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clock);
    #1;
    total++; if (alu_sel !== 4'd10) begin bad++; $display("FAIL rst_alu got=%0d want=10", alu_sel); end
    total++; if ({stall_f, flush_fd, pc_sel, br_un, mem_rw, reg_wen} !== 6'd0) begin bad++; $display("FAIL rst_flags got=%b want=000000", {stall_f, flush_fd, pc_sel, br_un, mem_rw, reg_wen}); end
    total++; if ({a_sel, b_sel, rs1_fwd_sel, rs2_fwd_sel, wb_sel, reg_waddr} !== 15'd0) begin bad++; $display("FAIL rst_sels got=%h want=0", {a_sel, b_sel, rs1_fwd_sel, rs2_fwd_sel, wb_sel, reg_waddr}); end
    total++; if (alu_sel_n !== 4'd10 || stall_f_n !== 1'b0) begin bad++; $display("FAIL rst_nb got alu=%0d stall=%0b want alu=10 stall=0", alu_sel_n, stall_f_n); end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // ADD x5,x1,x2 ; SUB x6,x5,x5 ; ADD x7,x5,x0
  task automatic test_forward();
    drv(1'b1, 1'b0, OP_R, 3'd0, 7'h00, 5'd1, 5'd2, 5'd5);
    @(negedge clock);
    total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL fwd_stall0 got=%0b want=0", stall_f); end
    push(1'b1, 5'd5);
    end_cycle();
    drv(1'b1, 1'b0, OP_R, 3'd0, 7'h20, 5'd5, 5'd5, 5'd6);
    @(negedge clock);
    total++; if (alu_sel !== 4'd0 || a_sel !== 2'b00) begin bad++; $display("FAIL fwd_add got alu=%0d a=%0d want alu=0 a=0", alu_sel, a_sel); end
    push(1'b1, 5'd6);
    end_cycle();
    drv(1'b1, 1'b0, OP_R, 3'd0, 7'h00, 5'd5, 5'd0, 5'd7);
    @(negedge clock);
    total++; if (a_sel !== 2'b11 || b_sel !== 2'b11) begin bad++; $display("FAIL fwd_mx got a=%0d b=%0d want a=3 b=3", a_sel, b_sel); end
    total++; if (alu_sel !== 4'd1) begin bad++; $display("FAIL fwd_sub got=%0d want=1", alu_sel); end
    total++; if (rs1_fwd_sel !== 2'b11 || rs2_fwd_sel !== 2'b11) begin bad++; $display("FAIL fwd_cmp got=%0d/%0d want=3/3", rs1_fwd_sel, rs2_fwd_sel); end
    push(1'b1, 5'd7);
    end_cycle();
    drv(1'b0, 1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clock);
    total++; if (a_sel !== 2'b10 || b_sel !== 2'b00) begin bad++; $display("FAIL fwd_wx got a=%0d b=%0d want a=2 b=0", a_sel, b_sel); end
    end_cycle();
    idle(4);
  endtask

  // ADD x5 ; ADDI x5,x5,1 ; ADD x7,x5,x5 -> newest producer (MX) wins
  task automatic test_mx_priority();
    drv(1'b1, 1'b0, OP_R, 3'd0, 7'h00, 5'd1, 5'd2, 5'd5);
    @(negedge clock); push(1'b1, 5'd5); end_cycle();
    drv(1'b1, 1'b0, OP_I, 3'd0, 7'h00, 5'd5, 5'd1, 5'd5);
    @(negedge clock); push(1'b1, 5'd5); end_cycle();
    drv(1'b1, 1'b0, OP_R, 3'd0, 7'h00, 5'd5, 5'd5, 5'd7);
    @(negedge clock);
    total++; if (a_sel !== 2'b11 || b_sel !== 2'b01) begin bad++; $display("FAIL pri_addi got a=%0d b=%0d want a=3 b=1", a_sel, b_sel); end
    push(1'b1, 5'd7);
    end_cycle();
    drv(1'b0, 1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clock);
    total++; if (a_sel !== 2'b11 || b_sel !== 2'b11) begin bad++; $display("FAIL pri_mx got a=%0d b=%0d want a=3 b=3", a_sel, b_sel); end
    end_cycle();
    idle(4);
  endtask

  // LW x3,0(x1) ; ADD x4,x3,x2
  task automatic test_load_use();
    drv(1'b1, 1'b0, OP_LOAD, 3'd2, 7'h00, 5'd1, 5'd0, 5'd3);
    @(negedge clock); push(1'b1, 5'd3); end_cycle();
    drv(1'b1, 1'b0, OP_R, 3'd0, 7'h00, 5'd3, 5'd2, 5'd4);
    @(negedge clock);
    total++; if (stall_f !== 1'b1 || flush_fd !== 1'b0) begin bad++; $display("FAIL lu_stall got stall=%0b flush=%0b want 1/0", stall_f, flush_fd); end
    end_cycle();
    @(negedge clock);
    total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL lu_release got=%0b want=0", stall_f); end
    total++; if (alu_sel !== 4'd10 || a_sel !== 2'b00) begin bad++; $display("FAIL lu_bubble got alu=%0d a=%0d want alu=10 a=0", alu_sel, a_sel); end
    total++; if (wb_sel !== 2'd0) begin bad++; $display("FAIL lu_wbmem got=%0d want=0", wb_sel); end
    push(1'b1, 5'd4);
    end_cycle();
    drv(1'b0, 1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clock);
    total++; if (a_sel !== 2'b10 || b_sel !== 2'b00) begin bad++; $display("FAIL lu_wx got a=%0d b=%0d want a=2 b=0", a_sel, b_sel); end
    end_cycle();
    idle(4);
  endtask

  // LW x3 ; BEQ x1,x2 (taken) with ADD x4,x3,x2 waiting ; then not-taken BEQ and taken BLTU
  task automatic test_branch_flush();
    drv(1'b1, 1'b1, OP_LOAD, 3'd2, 7'h00, 5'd1, 5'd0, 5'd3);
    @(negedge clock); push(1'b1, 5'd3); end_cycle();
    drv(1'b1, 1'b1, OP_BRANCH, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0);
    @(negedge clock);
    total++; if (stall_f_n !== 1'b0) begin bad++; $display("FAIL br_nostall got=%0b want=0", stall_f_n); end
    push(1'b0, 5'd0);
    end_cycle();
    drv(1'b1, 1'b1, OP_R, 3'd0, 7'h00, 5'd3, 5'd2, 5'd4);
    br_eq = 1'b1;
    @(negedge clock);
    total++; if (pc_sel !== 1'b1 || flush_fd !== 1'b1 || stall_f !== 1'b0) begin bad++; $display("FAIL br_taken got pc=%0b fl=%0b st=%0b want 1/1/0", pc_sel, flush_fd, stall_f); end
    total++; if (pc_sel_n !== 1'b1 || flush_fd_n !== 1'b1 || stall_f_n !== 1'b0) begin bad++; $display("FAIL br_taken_nb got pc=%0b fl=%0b st=%0b want 1/1/0", pc_sel_n, flush_fd_n, stall_f_n); end
    total++; if (a_sel !== 2'b01 || br_un !== 1'b0) begin bad++; $display("FAIL br_asel got a=%0d un=%0b want a=1 un=0", a_sel, br_un); end
    end_cycle();
    drv(1'b0, 1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    br_eq = 1'b0;
    @(negedge clock);
    total++; if (alu_sel !== 4'd10 || pc_sel !== 1'b0) begin bad++; $display("FAIL br_squash got alu=%0d pc=%0b want alu=10 pc=0", alu_sel, pc_sel); end
    end_cycle();
    idle(3);
    drv(1'b1, 1'b1, OP_BRANCH, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0);
    @(negedge clock); push(1'b0, 5'd0); end_cycle();
    drv(1'b0, 1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clock);
    total++; if (pc_sel !== 1'b0 || flush_fd !== 1'b0 || alu_sel !== 4'd0) begin bad++; $display("FAIL br_nottaken got pc=%0b fl=%0b alu=%0d want 0/0/0", pc_sel, flush_fd, alu_sel); end
    end_cycle();
    drv(1'b1, 1'b0, OP_BRANCH, 3'd6, 7'h00, 5'd1, 5'd2, 5'd0);
    @(negedge clock); push(1'b0, 5'd0); end_cycle();
    drv(1'b0, 1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    br_lt = 1'b1;
    @(negedge clock);
    total++; if (pc_sel !== 1'b1 || br_un !== 1'b1) begin bad++; $display("FAIL bltu got pc=%0b un=%0b want 1/1", pc_sel, br_un); end
    end_cycle();
    br_lt = 1'b0;
    idle(4);
  endtask

  // Forwarding disabled: ADD x5,x1,x2 ; ADD x6,x5,x0
  task automatic test_no_bypass();
    drv(1'b0, 1'b1, OP_R, 3'd0, 7'h00, 5'd1, 5'd2, 5'd5);
    @(negedge clock); end_cycle();
    drv(1'b0, 1'b1, OP_R, 3'd0, 7'h00, 5'd5, 5'd0, 5'd6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++; if (stall_f_n !== 1'b1) begin bad++; $display("FAIL nb_stall%0d got=%0b want=1", i, stall_f_n); end
      if (i == 2) begin
        total++; if (reg_wen_n !== 1'b1 || reg_waddr_n !== 5'd5) begin bad++; $display("FAIL nb_wb got wen=%0b addr=%0d want 1/5", reg_wen_n, reg_waddr_n); end
      end
      end_cycle();
    end
    @(negedge clock);
    total++; if (stall_f_n !== 1'b0) begin bad++; $display("FAIL nb_issue got=%0b want=0", stall_f_n); end
    end_cycle();
    drv(1'b0, 1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clock);
    total++; if (a_sel_n !== 2'b00 || rs1_fwd_sel_n !== 2'b00 || alu_sel_n !== 4'd0) begin bad++; $display("FAIL nb_dx got a=%0d f=%0d alu=%0d want 0/0/0", a_sel_n, rs1_fwd_sel_n, alu_sel_n); end
    end_cycle();
    idle(4);
  endtask

  // ADDI x0,x0,1 ; ADD x1,x0,x0 -> x0 never forwards, stalls, or writes
  task automatic test_x0();
    drv(1'b1, 1'b1, OP_I, 3'd0, 7'h00, 5'd0, 5'd1, 5'd0);
    @(negedge clock); push(1'b0, 5'd0); end_cycle();
    drv(1'b1, 1'b1, OP_R, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1);
    @(negedge clock);
    total++; if (stall_f !== 1'b0 || stall_f_n !== 1'b0) begin bad++; $display("FAIL x0_stall got=%0b/%0b want=0/0", stall_f, stall_f_n); end
    total++; if (b_sel !== 2'b01) begin bad++; $display("FAIL x0_addi_b got=%0d want=1", b_sel); end
    push(1'b1, 5'd1);
    end_cycle();
    drv(1'b0, 1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clock);
    total++; if (a_sel !== 2'b00 || b_sel !== 2'b00) begin bad++; $display("FAIL x0_nofwd got a=%0d b=%0d want 0/0", a_sel, b_sel); end
    end_cycle();
    @(negedge clock);
    total++; if (reg_wen_n !== 1'b0) begin bad++; $display("FAIL x0_wen_nb got=%0b want=0", reg_wen_n); end
    end_cycle();
    idle(4);
  endtask

  // ADD x5 ; SW x2,0(x1) ; JAL x1 in flight, then reset mid-cycle
  task automatic test_reset_mid();
    drv(1'b1, 1'b0, OP_R, 3'd0, 7'h00, 5'd1, 5'd2, 5'd5);
    @(negedge clock); push(1'b1, 5'd5); end_cycle();
    drv(1'b1, 1'b0, OP_STORE, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0);
    @(negedge clock); push(1'b0, 5'd0); end_cycle();
    drv(1'b1, 1'b0, OP_JAL, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1);
    @(negedge clock); push(1'b1, 5'd1); end_cycle();
    drv(1'b0, 1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    #1;
    total++; if (pc_sel !== 1'b1 || mem_rw !== 1'b1 || reg_wen !== 1'b1) begin bad++; $display("FAIL pre_rst got pc=%0b mw=%0b wen=%0b want 1/1/1", pc_sel, mem_rw, reg_wen); end
    total++; if (wb_sel !== 2'd1 || alu_sel !== 4'd0) begin bad++; $display("FAIL pre_rst_sel got wb=%0d alu=%0d want 1/0", wb_sel, alu_sel); end
    reset_n = 1'b0;
    #1;
    total++; if (reg_wen !== 1'b0 || mem_rw !== 1'b0 || pc_sel !== 1'b0 || alu_sel !== 4'd10) begin bad++; $display("FAIL mid_rst got wen=%0b mw=%0b pc=%0b alu=%0d want 0/0/0/10", reg_wen, mem_rw, pc_sel, alu_sel); end
    total++; if (flush_fd !== 1'b0 || wb_sel !== 2'd0 || reg_waddr !== 5'd0) begin bad++; $display("FAIL mid_rst2 got fl=%0b wb=%0d addr=%0d want 0/0/0", flush_fd, wb_sel, reg_waddr); end
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    idle(4);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_mx_priority();
    test_load_use();
    test_branch_flush();
    test_no_bypass();
    test_x0();
    test_reset_mid();
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
